// File: rtl/ps2_keycode_rx_pkg.sv
// Shared PS/2 scancode constants, receiver/echo state encodings and the hex-to-ASCII helper.
// The game FSM imports the same scancode values for its start/serve checks.
package ps2_keycode_rx_pkg;

   localparam logic [7:0] SC_BREAK = 8'hF0;
   localparam logic [7:0] SC_EXT   = 8'hE0;
   localparam logic [7:0] SC_UP    = 8'h75;
   localparam logic [7:0] SC_DOWN  = 8'h72;
   localparam logic [7:0] SP_CHAR  = 8'h20;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DATA   = 2'd1,
      ST_PARITY = 2'd2,
      ST_STOP   = 2'd3
   } ps2_state_t;

   typedef enum logic {
      EC_IDLE = 1'b0,
      EC_SEND = 1'b1
   } echo_state_t;

   function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
      return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
   endfunction

endpackage

// File: rtl/ps2_keycode_rx_uart_echo.sv
// Echo path: 4-entry byte FIFO, hex encoder and 8N1 transmitter; built only with PS2_UART_ECHO_EN.
// Commits arriving while the FIFO is full are dropped; the receiver never stalls.
`ifdef PS2_UART_ECHO_EN
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_wr_vld,
   input  logic [WIDTH-1:0] i_wr_dat,
   output logic             o_wr_rdy,
   output logic             o_rd_vld,
   output logic [WIDTH-1:0] o_rd_dat,
   input  logic             i_rd_rdy
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_count;
   logic             w_push;
   logic             w_pop;

   assign o_wr_rdy = (r_count != (AW+1)'(DEPTH));
   assign o_rd_vld = (r_count != '0);
   assign o_rd_dat = r_mem[r_rd_ptr];
   assign w_push   = i_wr_vld && o_wr_rdy;
   assign w_pop    = o_rd_vld && i_rd_rdy;

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= i_wr_dat;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= (r_wr_ptr == AW'(DEPTH-1)) ? '0 : r_wr_ptr + AW'(1);
         if (w_pop)  r_rd_ptr <= (r_rd_ptr == AW'(DEPTH-1)) ? '0 : r_rd_ptr + AW'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + (AW+1)'(1);
            2'b01:   r_count <= r_count - (AW+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end
endmodule

module ps2_uart_echo
   import ps2_keycode_rx_pkg::*;
#(
   parameter int CLK_HZ = 100_000_000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       i_byte_vld,
   input  logic [7:0] i_byte_dat,
   output logic       o_txd
);
   localparam int DIV = (CLK_HZ / 115200 > 0) ? CLK_HZ / 115200 : 1;
   localparam int BW  = $clog2(DIV + 1);

   echo_state_t   r_state;
   logic [7:0]    r_byte;
   logic [1:0]    r_char_idx;
   logic [9:0]    r_frame;
   logic [3:0]    r_bit_idx;
   logic [BW-1:0] r_baud;
   logic          r_txd;
   logic          w_rd_vld;
   logic [7:0]    w_rd_dat;
   logic          w_unused_wr_rdy;

   sync_fifo #(.WIDTH(8), .DEPTH(4)) u_fifo (
      .clk      (clk),
      .reset    (reset),
      .i_wr_vld (i_byte_vld),
      .i_wr_dat (i_byte_dat),
      .o_wr_rdy (w_unused_wr_rdy),
      .o_rd_vld (w_rd_vld),
      .o_rd_dat (w_rd_dat),
      .i_rd_rdy (r_state == EC_IDLE)
   );

   assign o_txd = r_txd;

   // Each byte goes out as three characters: high nibble, low nibble, space.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= EC_IDLE;
         r_byte     <= '0;
         r_char_idx <= '0;
         r_frame    <= '1;
         r_bit_idx  <= '0;
         r_baud     <= '0;
         r_txd      <= 1'b1;
      end else begin
         case (r_state)
            EC_IDLE: begin
               r_txd <= 1'b1;
               if (w_rd_vld) begin
                  r_byte     <= w_rd_dat;
                  r_char_idx <= 2'd0;
                  r_frame    <= {1'b1, hex_ascii(w_rd_dat[7:4]), 1'b0};
                  r_bit_idx  <= '0;
                  r_baud     <= '0;
                  r_state    <= EC_SEND;
               end
            end
            EC_SEND: begin
               r_txd <= r_frame[0];
               if (r_baud == BW'(DIV-1)) begin
                  r_baud  <= '0;
                  r_frame <= {1'b1, r_frame[9:1]};
                  if (r_bit_idx == 4'd9) begin
                     r_bit_idx <= '0;
                     if (r_char_idx == 2'd2) begin
                        r_state <= EC_IDLE;
                     end else begin
                        r_char_idx <= r_char_idx + 2'd1;
                        r_frame    <= {1'b1, (r_char_idx == 2'd0) ? hex_ascii(r_byte[3:0]) : SP_CHAR, 1'b0};
                     end
                  end else begin
                     r_bit_idx <= r_bit_idx + 4'd1;
                  end
               end else begin
                  r_baud <= r_baud + BW'(1);
               end
            end
            default: r_state <= EC_IDLE;
         endcase
      end
   end
endmodule
`endif

// File: rtl/ps2_keycode_rx.sv
// PS/2 keyboard receiver: sync + glitch filter + frame FSM, 4-byte scancode history and paddle-key held levels.
// Outputs update one cycle after the stop-bit strobe; no backpressure. PS2_UART_ECHO_EN adds the hex UART echo.
module ps2_keycode_rx
   import ps2_keycode_rx_pkg::*;
#(
   parameter int CLK_HZ      = 100_000_000,
   parameter int FILTER_LEN  = 8,
   parameter int TIMEOUT_CYC = 100_000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        ps2_clk,
   input  logic        ps2_data,
   output logic [31:0] keycode,
   output logic        byte_valid,
   output logic        frame_err,
   output logic        up_held,
   output logic        down_held,
   output logic        uart_txd
);
   localparam int FW = $clog2(FILTER_LEN + 1);
   localparam int TW = $clog2(TIMEOUT_CYC + 1);

   logic [1:0]    r_clk_sync;
   logic [1:0]    r_dat_sync;
   logic          r_filt_clk;
   logic [FW-1:0] r_filt_cnt;
   ps2_state_t    r_state;
   logic [2:0]    r_bit_cnt;
   logic [7:0]    r_shift;
   logic          r_parity;
   logic [TW-1:0] r_timer;
   logic          r_break_pend;
   logic          w_clk_s;
   logic          w_dat_s;
   logic          w_flip;
   logic          w_strobe;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_clk_sync <= 2'b11;
         r_dat_sync <= 2'b11;
      end else begin
         r_clk_sync <= {r_clk_sync[0], ps2_clk};
         r_dat_sync <= {r_dat_sync[0], ps2_data};
      end
   end

   assign w_clk_s  = r_clk_sync[1];
   assign w_dat_s  = r_dat_sync[1];
   assign w_flip   = (w_clk_s != r_filt_clk) && (r_filt_cnt == FW'(FILTER_LEN-1));
   assign w_strobe = w_flip && r_filt_clk;

   // The filtered clock follows only after FILTER_LEN consecutive disagreeing samples.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_filt_clk <= 1'b1;
         r_filt_cnt <= '0;
      end else if (w_clk_s == r_filt_clk) begin
         r_filt_cnt <= '0;
      end else if (w_flip) begin
         r_filt_clk <= w_clk_s;
         r_filt_cnt <= '0;
      end else begin
         r_filt_cnt <= r_filt_cnt + FW'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state      <= ST_IDLE;
         r_bit_cnt    <= '0;
         r_shift      <= '0;
         r_parity     <= 1'b0;
         r_timer      <= '0;
         r_break_pend <= 1'b0;
         keycode      <= '0;
         byte_valid   <= 1'b0;
         frame_err    <= 1'b0;
         up_held      <= 1'b0;
         down_held    <= 1'b0;
      end else begin
         byte_valid <= 1'b0;
         frame_err  <= 1'b0;
         if (w_strobe) begin
            r_timer <= '0;
            case (r_state)
               ST_IDLE: begin
                  if (!w_dat_s) begin
                     r_state   <= ST_DATA;
                     r_bit_cnt <= '0;
                  end
               end
               ST_DATA: begin
                  r_shift   <= {w_dat_s, r_shift[7:1]};
                  r_bit_cnt <= r_bit_cnt + 3'd1;
                  if (r_bit_cnt == 3'd7) r_state <= ST_PARITY;
               end
               ST_PARITY: begin
                  r_parity <= w_dat_s;
                  r_state  <= ST_STOP;
               end
               ST_STOP: begin
                  r_state <= ST_IDLE;
                  if (w_dat_s && (^{r_shift, r_parity})) begin
                     keycode    <= {keycode[23:0], r_shift};
                     byte_valid <= 1'b1;
                     // E0 is transparent so an extended break (E0 F0 xx) still releases the key.
                     if (r_shift == SC_BREAK) begin
                        r_break_pend <= 1'b1;
                     end else if (r_shift != SC_EXT) begin
                        r_break_pend <= 1'b0;
                        if (r_shift == SC_UP)   up_held   <= ~r_break_pend;
                        if (r_shift == SC_DOWN) down_held <= ~r_break_pend;
                     end
                  end else begin
                     frame_err <= 1'b1;
                  end
               end
               default: r_state <= ST_IDLE;
            endcase
         end else if (r_state != ST_IDLE) begin
            if (r_timer == TW'(TIMEOUT_CYC-1)) begin
               r_state   <= ST_IDLE;
               r_timer   <= '0;
               frame_err <= 1'b1;
            end else begin
               r_timer <= r_timer + TW'(1);
            end
         end else begin
            r_timer <= '0;
         end
      end
   end

`ifdef PS2_UART_ECHO_EN
   ps2_uart_echo #(.CLK_HZ(CLK_HZ)) u_echo (
      .clk        (clk),
      .reset      (reset),
      .i_byte_vld (byte_valid),
      .i_byte_dat (keycode[7:0]),
      .o_txd      (uart_txd)
   );
`else
   // The baud divider is the only consumer of CLK_HZ.
   logic w_unused_cfg;
   assign w_unused_cfg = (CLK_HZ != 0);
   assign uart_txd     = 1'b1;
`endif

endmodule
